// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the receiver FSM state encoding, the default frame and oversample
// parameters (also used by the baud/oversample tick generator, so both sides
// agree on OVERSAMPLE_AMOUNT), and the 3-input majority helper that resolves
// the mid-bit vote.
package uart_pkg;

  localparam int DATA_BITS_DEFAULT  = 8;
  localparam int OVERSAMPLE_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops reset to 1, which matches an idle-high serial line, so a reset
// never produces a spurious low edge downstream.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronized output (2 clk latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1 by default, LSB first) with mid-bit majority voting.
// The line is synchronized, then sampled on every oversample tick. Each bit
// is decided by a 2-of-3 vote over the samples at ctr = OS/2-1, OS/2, OS/2+1.
// Received bytes are offered on a valid/ready interface.
//
// Handshake: rx_valid rises when a byte completes and stays high, with
// rx_data stable, until a clk edge on which rx_valid & rx_ready are both 1.
// rx_ready while rx_valid = 0 has no effect. A byte that completes while the
// previous one is still held (and not being accepted on that same edge) is
// dropped and reported by a one-clk overrun pulse.
//
// Ports:
//   clk             - system clock
//   rst_n           - asynchronous active-low reset
//   oversample_tick - one-clk pulse, OVERSAMPLE_AMOUNT per bit period
//   rx              - asynchronous serial input, idle high
//   rx_data         - received byte, stable while rx_valid = 1
//   rx_valid        - byte available, held until accepted
//   rx_ready        - consumer accept
//   frame_err       - one-clk pulse: stop bit voted low
//   overrun         - one-clk pulse: byte lost because previous one unaccepted
//   busy            - receiver not in IDLE
//   fsm_state       - current FSM state, for observation
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS         = DATA_BITS_DEFAULT,
  parameter int OVERSAMPLE_AMOUNT = OVERSAMPLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 oversample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output state_t               fsm_state
);

  localparam int CW = $clog2(OVERSAMPLE_AMOUNT);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CTR_MID_LO = CW'(OVERSAMPLE_AMOUNT / 2 - 1);
  localparam logic [CW-1:0] CTR_MID    = CW'(OVERSAMPLE_AMOUNT / 2);
  localparam logic [CW-1:0] CTR_MID_HI = CW'(OVERSAMPLE_AMOUNT / 2 + 1);
  localparam logic [CW-1:0] CTR_LAST   = CW'(OVERSAMPLE_AMOUNT - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);

  logic rx_s;

  state_t               state_q, state_d;
  logic [CW-1:0]        ctr_q, ctr_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 s0_q, s0_d;
  logic                 s1_q, s1_d;
  logic                 vote;
  logic                 done;
  logic                 bad_stop;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Third sample is the live synchronized line on the ctr = OS/2+1 tick.
  assign vote = maj3(s0_q, s1_q, rx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ctr_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    done      = 1'b0;
    bad_stop  = 1'b0;

    if (oversample_tick) begin
      if (state_q == START || state_q == DATA || state_q == STOP) begin
        ctr_d = ctr_q + 1'b1;
        if (ctr_q == CTR_MID_LO) s0_d = rx_s;
        if (ctr_q == CTR_MID)    s1_d = rx_s;
      end

      unique case (state_q)
        IDLE: begin
          // The detecting tick is sample 0 of the start bit.
          if (!rx_s) begin
            state_d = START;
            ctr_d   = CW'(1);
          end
        end
        START: begin
          if (ctr_q == CTR_MID_HI && vote) begin
            state_d = IDLE;
            ctr_d   = '0;
          end else if (ctr_q == CTR_LAST) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
        DATA: begin
          if (ctr_q == CTR_MID_HI) begin
            shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
          end
          if (ctr_q == CTR_LAST) begin
            if (bit_idx_q == BIT_LAST) begin
              state_d   = STOP;
              bit_idx_d = '0;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end
        end
        STOP: begin
          // Leaving mid stop bit lets a back-to-back start edge be caught.
          if (ctr_q == CTR_MID_HI) begin
            ctr_d = '0;
            if (vote) begin
              state_d = IDLE;
              done    = 1'b1;
            end else begin
              state_d  = WAIT_HIGH;
              bad_stop = 1'b1;
            end
          end
        end
        WAIT_HIGH: begin
          // Hold off until the line idles so a break cannot retrigger.
          if (rx_s) begin
            state_d = IDLE;
            ctr_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          ctr_d   = '0;
        end
      endcase
    end
  end

  // Output handshake runs every clk, independent of the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg_q;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int TICK_DIV = 54;

  // ---------------- clock / reset / tick ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  int   div_cnt = 0;
  logic rx = 1'b1;
  logic rx_ready = 1'b0;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  state_t     fsm_state;

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (div_cnt == TICK_DIV - 1) begin
      div_cnt <= 0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1;
      tick    <= 1'b0;
    end
  end

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE_AMOUNT(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .oversample_tick (tick),
    .rx              (rx),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .frame_err       (frame_err),
    .overrun         (overrun),
    .busy            (busy),
    .fsm_state       (fsm_state)
  );

  // ---------------- output monitor (sampled on falling edge) ----------------
  int         valid_cycles = 0;
  int         valid_rises = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         both_cnt = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] last_data = 8'h00;

  always @(negedge clk) begin
    if (rx_valid) valid_cycles <= valid_cycles + 1;
    if (rx_valid && !valid_prev) begin
      valid_rises <= valid_rises + 1;
      last_data   <= rx_data;
    end
    valid_prev <= rx_valid;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (frame_err && overrun) both_cnt <= both_cnt + 1;
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns 1 ns after the next clk edge on which the DUT saw a tick.
  task automatic wait_tick();
    int n;
    n = 0;
    @(posedge clk);
    while (tick !== 1'b1 && n < 4 * TICK_DIV) begin
      @(posedge clk);
      n++;
    end
    if (n >= 4 * TICK_DIV) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tick_timeout: no tick within %0d clk", n);
    end
    #1;
  endtask

  task automatic drive_ticks(input logic level, input int n);
    for (int i = 0; i < n; i++) begin
      rx = level;
      wait_tick();
    end
  endtask

  // One frame: start bit, 8 data bits LSB first, then stop_low ticks of
  // low level followed by stop_high ticks of high level. With jit set, the
  // edge before data bit k moves +2 ticks (k even) or -2 ticks (k odd).
  task automatic send_frame(input logic [7:0] d, input logic jit,
                            input int stop_low, input int stop_high);
    int e[9];
    logic lvl;
    for (int k = 0; k < 8; k++)
      e[k] = 8 * (k + 1) + (jit ? ((k % 2 == 0) ? 2 : -2) : 0);
    e[8] = 72;
    for (int t = 0; t < 72 + stop_low + stop_high; t++) begin
      if (t < e[0]) lvl = 1'b0;
      else if (t >= 72) lvl = (t < 72 + stop_low) ? 1'b0 : 1'b1;
      else begin
        lvl = 1'b1;
        for (int k = 0; k < 8; k++)
          if (t >= e[k] && t < e[k+1]) lvl = d[k];
      end
      rx = lvl;
      wait_tick();
    end
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] data;
    logic       jit;
    logic [7:0] exp_data;
    int         exp_valid_cycles;
  } vec_t;

  vec_t vecs[4];

  int s_rises, s_cyc, s_ferr, s_ovr;

  initial begin
    vecs[0] = '{data: 8'hA5, jit: 1'b0, exp_data: 8'hA5, exp_valid_cycles: 1};
    vecs[1] = '{data: 8'h5A, jit: 1'b0, exp_data: 8'h5A, exp_valid_cycles: 1};
    vecs[2] = '{data: 8'hFF, jit: 1'b0, exp_data: 8'hFF, exp_valid_cycles: 1};
    vecs[3] = '{data: 8'h01, jit: 1'b1, exp_data: 8'h01, exp_valid_cycles: 1};

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    drive_ticks(1'b1, 4);

    // Table: single frames with rx_ready held high
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_rises = valid_rises; s_cyc = valid_cycles; s_ferr = ferr_cnt; s_ovr = ovr_cnt;
      send_frame(vecs[i].data, vecs[i].jit, 0, 8);
      drive_ticks(1'b1, 2);
      check($sformatf("vec%0d_data", i), 32'(last_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_rises", i), 32'(valid_rises - s_rises), 32'd1);
      check($sformatf("vec%0d_valid_cycles", i), 32'(valid_cycles - s_cyc),
            32'(vecs[i].exp_valid_cycles));
      check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - s_ferr), 32'd0);
      check($sformatf("vec%0d_ovr", i), 32'(ovr_cnt - s_ovr), 32'd0);
    end
    rx_ready = 1'b0;

    // Held byte, then a single-clk accept
    send_frame(8'h3C, 1'b0, 0, 8);
    drive_ticks(1'b1, 8);
    check("hold_valid", 32'(rx_valid), 32'h1);
    check("hold_data", 32'(rx_data), 32'h3C);
    pulse_ready();
    check("accept_valid_low", 32'(rx_valid), 32'h0);

    // Back-to-back frames while unaccepted -> overrun
    s_rises = valid_rises; s_ovr = ovr_cnt; s_ferr = ferr_cnt;
    send_frame(8'h55, 1'b0, 0, 8);
    check("b2b_no_ovr_yet", 32'(ovr_cnt - s_ovr), 32'd0);
    send_frame(8'h0F, 1'b0, 0, 8);
    drive_ticks(1'b1, 2);
    check("ovr_count", 32'(ovr_cnt - s_ovr), 32'd1);
    check("ovr_data_kept", 32'(rx_data), 32'h55);
    check("ovr_valid_kept", 32'(rx_valid), 32'h1);
    check("ovr_rises", 32'(valid_rises - s_rises), 32'd1);
    check("ovr_no_ferr", 32'(ferr_cnt - s_ferr), 32'd0);
    pulse_ready();
    check("ovr_accept", 32'(rx_valid), 32'h0);

    // Stop bit held low for 3 bit periods -> framing error, then recovery
    s_rises = valid_rises; s_ferr = ferr_cnt; s_ovr = ovr_cnt;
    send_frame(8'h00, 1'b0, 24, 0);
    check("ferr_count", 32'(ferr_cnt - s_ferr), 32'd1);
    check("ferr_no_valid", 32'(valid_rises - s_rises), 32'd0);
    check("ferr_valid_low", 32'(rx_valid), 32'h0);
    check("ferr_busy_while_low", 32'(busy), 32'h1);
    check("ferr_state_wait_high", 32'(fsm_state), 32'(WAIT_HIGH));
    drive_ticks(1'b1, 4);
    check("ferr_busy_released", 32'(busy), 32'h0);
    rx_ready = 1'b1;
    send_frame(8'h81, 1'b0, 0, 8);
    drive_ticks(1'b1, 2);
    check("after_ferr_data", 32'(last_data), 32'h81);
    check("after_ferr_rises", 32'(valid_rises - s_rises), 32'd1);
    check("after_ferr_no_ovr", 32'(ovr_cnt - s_ovr), 32'd0);
    rx_ready = 1'b0;

    // Two-tick low glitch on idle line
    s_rises = valid_rises; s_ferr = ferr_cnt;
    drive_ticks(1'b0, 2);
    check("glitch_busy_started", 32'(busy), 32'h1);
    drive_ticks(1'b1, 6);
    check("glitch_busy_cleared", 32'(busy), 32'h0);
    check("glitch_no_valid", 32'(valid_rises - s_rises), 32'd0);
    check("glitch_no_ferr", 32'(ferr_cnt - s_ferr), 32'd0);

    // Reset during bit 4 of a frame, with a byte already held
    send_frame(8'h7E, 1'b0, 0, 8);
    check("pre_rst_valid", 32'(rx_valid), 32'h1);
    drive_ticks(1'b0, 8);
    drive_ticks(1'b1, 8);
    drive_ticks(1'b0, 8);
    drive_ticks(1'b0, 8);
    drive_ticks(1'b1, 8);
    drive_ticks(1'b1, 4);
    rst_n = 1'b0;
    #1;
    check("midrst_rx_data", 32'(rx_data), 32'h00);
    check("midrst_rx_valid", 32'(rx_valid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_frame_err", 32'(frame_err), 32'h0);
    check("midrst_overrun", 32'(overrun), 32'h0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_ticks(1'b1, 4);

    s_rises = valid_rises; s_ferr = ferr_cnt;
    rx_ready = 1'b1;
    send_frame(8'hC3, 1'b0, 0, 8);
    drive_ticks(1'b1, 2);
    check("post_rst_data", 32'(last_data), 32'hC3);
    check("post_rst_rises", 32'(valid_rises - s_rises), 32'd1);
    send_frame(8'hC3, 1'b1, 0, 8);
    drive_ticks(1'b1, 2);
    check("jitter_data", 32'(last_data), 32'hC3);
    check("jitter_rises", 32'(valid_rises - s_rises), 32'd2);
    check("post_rst_no_ferr", 32'(ferr_cnt - s_ferr), 32'd0);
    rx_ready = 1'b0;

    check("never_ferr_and_ovr", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
